// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD combinational read ports, two write ports, r0 reads zero,
// post-reset clear sequencer. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     init_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] regs_q [DEPTH];

    logic run_active;
    logic wr0_en;
    logic wr1_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                state_d = RUN;
            end
        end
    end

    assign run_active = !rst && (state_q == RUN);
    // Port 1 wins a same-address collision, so port 0 is suppressed outright.
    assign wr1_en = run_active && we1 && (waddr1 != '0);
    assign wr0_en = run_active && we0 && (waddr0 != '0) && !(wr1_en && (waddr1 == waddr0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                regs_q[clr_cnt_q] <= '0;
            end else begin
                if (wr0_en) begin
                    regs_q[waddr0] <= wdata0;
                end
                if (wr1_en) begin
                    regs_q[waddr1] <= wdata1;
                end
            end
        end
    end

    assign init_done = (state_q == RUN);

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[g*ADDR_W +: ADDR_W];

        always_comb begin
            rd = '0;
            if (run_active && re[g] && (ra != '0)) begin
                rd = regs_q[ra];
`ifdef REGFILE_BYPASS_EN
                if (we1 && (waddr1 == ra)) begin
                    rd = wdata1;
                end else if (we0 && (waddr0 == ra)) begin
                    rd = wdata0;
                end
`else
`endif
            end
        end

        assign rdata[g*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp (4 read ports) against an array-based reference model.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     we0;
    logic [ADDR_W-1:0]        waddr0;
    logic [DATA_W-1:0]        wdata0;
    logic                     we1;
    logic [ADDR_W-1:0]        waddr1;
    logic [DATA_W-1:0]        wdata1;
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic                     init_done;

    int checks = 0;
    int fails  = 0;

    logic [DATA_W-1:0] model [DEPTH];
    int clearLeft = DEPTH;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we0      (we0),
        .waddr0   (waddr0),
        .wdata0   (wdata0),
        .we1      (we1),
        .waddr1   (waddr1),
        .wdata1   (wdata1),
        .re       (re),
        .raddr    (raddr),
        .rdata    (rdata),
        .init_done(init_done)
    );

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference read: zero unless the file is clean, enabled and nonzero-addressed.
    function automatic logic [DATA_W-1:0] expRead(input int i);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;
        a = raddr[i*ADDR_W +: ADDR_W];
        v = '0;
        if (!rst && clearLeft == 0 && re[i] && a != '0) begin
            v = model[a];
`ifdef REGFILE_BYPASS_EN
            if (we1 && waddr1 == a) v = wdata1;
            else if (we0 && waddr0 == a) v = wdata0;
`endif
        end
        return v;
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, "/init"}, {31'b0, init_done}, {31'b0, clearLeft == 0});
        for (int i = 0; i < NUM_RD; i++) begin
            checkOutput($sformatf("%s/rd%0d", tag, i), rdata[i*DATA_W +: DATA_W], expRead(i));
        end
    endtask

    // One clock edge: update the model from the inputs the DUT sees, then step off the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            clearLeft = DEPTH;
            for (int k = 0; k < DEPTH; k++) model[k] = '0;
        end else if (clearLeft > 0) begin
            clearLeft--;
        end else begin
            if (we0 && waddr0 != '0) model[waddr0] = wdata0;
            if (we1 && waddr1 != '0) model[waddr1] = wdata1;
        end
        #1;
    endtask

    task automatic cycle(input string tag);
        #3;
        checkAll(tag);
        tick();
    endtask

    task automatic applyStimulus(input logic w0, input int a0, input logic [DATA_W-1:0] d0,
                                 input logic w1, input int a1, input logic [DATA_W-1:0] d1);
        we0    = w0;
        waddr0 = ADDR_W'(a0);
        wdata0 = d0;
        we1    = w1;
        waddr1 = ADDR_W'(a1);
        wdata1 = d1;
    endtask

    task automatic setRead(input int port, input int addr);
        raddr[port*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    endtask

    initial begin
        rst = 1'b1;
        re  = '0;
        raddr = '0;
        applyStimulus(1'b0, 0, '0, 1'b0, 0, '0);
        tick();
        tick();
        #3;
        checkAll("reset");

        // Clear sequence: init_done low for the full depth, then high.
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) cycle("clear");
        #3;
        checkOutput("init_at_32", {31'b0, init_done}, 32'd1);
        re = '1;
        for (int b = 0; b < DEPTH; b += NUM_RD) begin
            for (int p = 0; p < NUM_RD; p++) setRead(p, b + p);
            cycle("zeroread");
        end

        // Write r3 and read it back the same and next cycle.
        re = 4'b0001;
        setRead(0, 3);
        applyStimulus(1'b1, 3, 32'h0000_0005, 1'b0, 0, '0);
        cycle("wr_r3");
        applyStimulus(1'b0, 0, '0, 1'b0, 0, '0);
        #3;
        checkOutput("r3_next", rdata[0 +: DATA_W], 32'h5);
        cycle("r3_hold");

        // Same-address collision: port 1 wins.
        re = '1;
        setRead(1, 4);
        applyStimulus(1'b1, 4, 32'h11, 1'b1, 4, 32'h22);
        cycle("collide");
        applyStimulus(1'b0, 0, '0, 1'b0, 0, '0);
        #3;
        checkOutput("r4_port1_wins", rdata[DATA_W +: DATA_W], 32'h22);
        cycle("r4_hold");

        // Writes to r0 are dropped; disabled ports read zero.
        setRead(0, 0);
        applyStimulus(1'b0, 0, '0, 1'b1, 0, 32'hFFFF_FFFF);
        cycle("wr_r0");
        applyStimulus(1'b0, 0, '0, 1'b0, 0, '0);
        #3;
        checkOutput("r0_next", rdata[0 +: DATA_W], 32'h0);
        cycle("r0_hold");
        re = 4'b0000;
        setRead(1, 4);
        setRead(2, 3);
        #3;
        checkOutput("re_off", rdata[DATA_W +: DATA_W], 32'h0);
        cycle("re_off_all");

        // Randomised traffic with addresses biased toward collisions.
        for (int n = 0; n < 400; n++) begin
            we0    = 1'($urandom_range(0, 1));
            we1    = 1'($urandom_range(0, 1));
            waddr0 = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
            waddr1 = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
            wdata0 = $urandom;
            wdata1 = $urandom;
            re     = NUM_RD'($urandom);
            for (int p = 0; p < NUM_RD; p++) setRead(p, $urandom_range(0, 7));
            cycle("rand");
        end

        // Four ports reading r1, r2, r1, r0.
        re = '1;
        applyStimulus(1'b1, 1, 32'h1, 1'b1, 2, 32'h2);
        cycle("wr_r1_r2");
        applyStimulus(1'b0, 0, '0, 1'b0, 0, '0);
        setRead(0, 1);
        setRead(1, 2);
        setRead(2, 1);
        setRead(3, 0);
        #3;
        checkOutput("p0_r1", rdata[0*DATA_W +: DATA_W], 32'h1);
        checkOutput("p1_r2", rdata[1*DATA_W +: DATA_W], 32'h2);
        checkOutput("p2_r1", rdata[2*DATA_W +: DATA_W], 32'h1);
        checkOutput("p3_r0", rdata[3*DATA_W +: DATA_W], 32'h0);
        cycle("four_ports");

        // Reset during clear restarts it; writes during clear are ignored.
        applyStimulus(1'b1, 7, 32'hA5A5_A5A5, 1'b0, 0, '0);
        cycle("wr_r7");
        applyStimulus(1'b0, 0, '0, 1'b0, 0, '0);
        rst = 1'b1;
        cycle("rst_a");
        rst = 1'b0;
        for (int k = 0; k < 9; k++) cycle("clr_part");
        rst = 1'b1;
        cycle("rst_b");
        rst = 1'b0;
        applyStimulus(1'b1, 9, 32'h99, 1'b0, 0, '0);
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 4) applyStimulus(1'b0, 0, '0, 1'b0, 0, '0);
            cycle("clr_full");
        end
        setRead(0, 7);
        setRead(1, 9);
        #3;
        checkOutput("init_after_restart", {31'b0, init_done}, 32'd1);
        checkOutput("r7_cleared", rdata[0 +: DATA_W], 32'h0);
        checkOutput("r9_untouched", rdata[DATA_W +: DATA_W], 32'h0);
        cycle("final");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
